// File: rtl/aes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_pkg : GF(2^8) helpers, column-mix functions, scheduler FSM enum  |
// | Optional feature macro: MIXCOL_SCHED_INV_EN (inverse column mix)     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package aes_pkg;

  localparam int c_bytew  = 8;
  localparam int c_colw   = 32;
  localparam int c_ncol   = 4;
  localparam int c_statew = c_colw * c_ncol;

  localparam logic [7:0] c_gf_poly = 8'h1b;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? c_gf_poly : 8'h00);
  endfunction

  function automatic logic [7:0] mul3(input logic [7:0] b);
    mul3 = xtime(b) ^ b;
  endfunction

  function automatic logic [c_colw-1:0] mix_col_fwd(input logic [c_colw-1:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[0*c_bytew +: c_bytew];
    a1 = c[1*c_bytew +: c_bytew];
    a2 = c[2*c_bytew +: c_bytew];
    a3 = c[3*c_bytew +: c_bytew];
    mix_col_fwd = {mul3(a0) ^ a1 ^ a2 ^ xtime(a3),
                   a0 ^ a1 ^ xtime(a2) ^ mul3(a3),
                   a0 ^ xtime(a1) ^ mul3(a2) ^ a3,
                   xtime(a0) ^ mul3(a1) ^ a2 ^ a3};
  endfunction

`ifdef MIXCOL_SCHED_INV_EN
  function automatic logic [7:0] mul9(input logic [7:0] b);
    mul9 = xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] mulb(input logic [7:0] b);
    mulb = xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] muld(input logic [7:0] b);
    muld = xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] mule(input logic [7:0] b);
    mule = xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  function automatic logic [c_colw-1:0] mix_col_inv(input logic [c_colw-1:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[0*c_bytew +: c_bytew];
    a1 = c[1*c_bytew +: c_bytew];
    a2 = c[2*c_bytew +: c_bytew];
    a3 = c[3*c_bytew +: c_bytew];
    mix_col_inv = {mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3),
                   muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3),
                   mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3),
                   mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3)};
  endfunction
`endif

endpackage
`default_nettype wire

// File: rtl/mixcol_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mixcol_sched_if : requester and result handshakes of mixcol_sched    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface mixcol_sched_if #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) ();

  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [128*NREQ-1:0] req_data;
  logic [NREQ-1:0]     req_inv;
  logic                out_valid;
  logic                out_ready;
  logic [127:0]        out_data;
  logic [IDW-1:0]      out_id;

  modport master (
    output req_valid, req_data, req_inv, out_ready,
    input  req_ready, out_valid, out_data, out_id
  );

  modport slave (
    input  req_valid, req_data, req_inv, out_ready,
    output req_ready, out_valid, out_data, out_id
  );

endinterface
`default_nettype wire

// File: rtl/mix_column_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mix_column_unit : combinational single-column MixColumns             |
// | Optional feature macro: MIXCOL_SCHED_INV_EN (adds inverse matrix)    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mix_column_unit
  import aes_pkg::*;
(
  input  logic [c_colw-1:0] col_in,
  input  logic              inv,
  output logic [c_colw-1:0] col_out
);

`ifdef MIXCOL_SCHED_INV_EN
  assign col_out = inv ? mix_col_inv(col_in) : mix_col_fwd(col_in);
`else
  logic unused_inv;
  assign unused_inv = inv;
  assign col_out    = mix_col_fwd(col_in);
`endif

endmodule
`default_nettype wire

// File: rtl/mixcol_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mixcol_sched : round-robin scheduler sharing one MixColumns column   |
// |                unit between NREQ lanes, one column per clock         |
// | Optional feature macro: MIXCOL_SCHED_INV_EN (inverse mix requests)   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mixcol_sched
  import aes_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  mixcol_sched_if.slave      bus,
  output logic               busy
);

  state_e                state_q, state_d;
  logic [1:0]            col_q, col_d;
  logic [IDW-1:0]        last_id_q, last_id_d;
  logic [IDW-1:0]        id_q, id_d;
  logic [c_statew-1:0]   work_q, work_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q, busy_d;

  logic [NREQ-1:0]       grant;
  logic [IDW-1:0]        grant_id;
  logic [IDW-1:0]        cand;
  logic                  found;
  logic                  accept;
  logic [c_statew-1:0]   sel_data;
  logic [c_colw-1:0]     col_in;
  logic [c_colw-1:0]     col_out;
  logic                  mix_inv;

`ifdef MIXCOL_SCHED_INV_EN
  logic                  inv_q, inv_d;
  logic                  sel_inv;
  assign mix_inv = inv_q;
`else
  logic                  unused_req_inv;
  assign unused_req_inv = ^bus.req_inv;
  assign mix_inv        = 1'b0;
`endif

  // Search starts one past the last served lane, so every lane is reached within NREQ grants.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    cand     = '0;
    found    = 1'b0;
    if (state_q == IDLE && !rst) begin
      for (int k = 1; k <= NREQ; k++) begin
        cand = IDW'((int'(last_id_q) + k) % NREQ);
        if (!found && bus.req_valid[cand]) begin
          found       = 1'b1;
          grant[cand] = 1'b1;
          grant_id    = cand;
        end
      end
    end
  end

  assign accept        = found;
  assign bus.req_ready = grant;

  always_comb begin
    sel_data = '0;
`ifdef MIXCOL_SCHED_INV_EN
    sel_inv  = 1'b0;
`endif
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_data = bus.req_data[c_statew*i +: c_statew];
`ifdef MIXCOL_SCHED_INV_EN
        sel_inv  = bus.req_inv[i];
`endif
      end
    end
  end

  assign col_in = work_q[c_colw*col_q +: c_colw];

  mix_column_unit u_mix (
    .col_in  (col_in),
    .inv     (mix_inv),
    .col_out (col_out)
  );

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    last_id_d = last_id_q;
    id_d      = id_q;
    work_d    = work_q;
`ifdef MIXCOL_SCHED_INV_EN
    inv_d     = inv_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          work_d    = sel_data;
          id_d      = grant_id;
          last_id_d = grant_id;
`ifdef MIXCOL_SCHED_INV_EN
          inv_d     = sel_inv;
`endif
          col_d     = 2'd0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        // The column is overwritten in place; work_q doubles as the result register.
        work_d[c_colw*col_q +: c_colw] = col_out;
        col_d = col_q + 2'd1;
        if (col_q == 2'(c_ncol - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      col_q       <= 2'd0;
      last_id_q   <= IDW'(NREQ - 1);
      id_q        <= '0;
      work_q      <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MIXCOL_SCHED_INV_EN
      inv_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      last_id_q   <= last_id_d;
      id_q        <= id_d;
      work_q      <= work_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef MIXCOL_SCHED_INV_EN
      inv_q       <= inv_d;
`endif
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = work_q;
  assign bus.out_id    = id_q;
  assign busy          = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mixcol_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mixcol_sched : directed vector bench for mixcol_sched             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mixcol_sched;

  localparam int NREQ = 2;
  localparam int IDW  = 1;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  mixcol_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  mixcol_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string        name;
    logic [127:0] data;
    logic         inv;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[5];

  function automatic logic [127:0] st(input logic [31:0] c3, input logic [31:0] c2,
                                      input logic [31:0] c1, input logic [31:0] c0);
    st = {c3, c2, c1, c0};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_out_valid(input string name);
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, " out_valid within bound"}, 128'(bus.out_valid), 128'd1);
  endtask

  task automatic run_one(input string name, input int lane, input logic [127:0] d,
                         input logic inv, input logic [127:0] exp);
    int n;
    @(negedge clk);
    bus.req_data[lane*128 +: 128] = d;
    bus.req_inv[lane]             = inv;
    bus.req_valid[lane]           = 1'b1;
    #1;
    n = 0;
    while (bus.req_ready[lane] !== 1'b1 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({name, " grant"}, 128'(bus.req_ready[lane]), 128'd1);
    @(negedge clk);
    bus.req_valid[lane] = 1'b0;
    bus.req_inv[lane]   = 1'b0;
    repeat (3) @(negedge clk);
    check({name, " out_valid low after E3"}, 128'(bus.out_valid), 128'd0);
    @(negedge clk);
    check({name, " out_valid high after E4"}, 128'(bus.out_valid), 128'd1);
    check({name, " out_data"}, bus.out_data, exp);
    check({name, " out_id"}, 128'(bus.out_id), 128'(lane));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({name, " out_valid after handshake"}, 128'(bus.out_valid), 128'd0);
    check({name, " busy after handshake"}, 128'(busy), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{"single col0", st(32'h01010101, 32'h01010101, 32'h01010101, 32'h455313db), 1'b0,
                st(32'h01010101, 32'h01010101, 32'h01010101, 32'hbca14d8e)};
    vecs[1] = '{"all c6", st(32'hc6c6c6c6, 32'hc6c6c6c6, 32'hc6c6c6c6, 32'hc6c6c6c6), 1'b0,
                st(32'hc6c6c6c6, 32'hc6c6c6c6, 32'hc6c6c6c6, 32'hc6c6c6c6)};
    vecs[2] = '{"all 01", st(32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101), 1'b0,
                st(32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101)};
    vecs[3] = '{"mixed cols", st(32'h5c220af2, 32'h455313db, 32'h4c31262d, 32'hd5d4d4d4), 1'b0,
                st(32'h9d58dc9f, 32'hbca14d8e, 32'hf8bd7e4d, 32'hd6d7d5d5)};
`ifdef MIXCOL_SCHED_INV_EN
    vecs[4] = '{"inv request", st(32'h01010101, 32'h01010101, 32'h01010101, 32'hbca14d8e), 1'b1,
                st(32'h01010101, 32'h01010101, 32'h01010101, 32'h455313db)};
`else
    vecs[4] = '{"inv ignored", st(32'h01010101, 32'h01010101, 32'h01010101, 32'hbca14d8e), 1'b1,
                st(32'h01010101, 32'h01010101, 32'h01010101, 32'h064550cd)};
`endif

    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_inv   = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state, with both lanes already requesting.
    bus.req_data  = {st(32'h5c220af2, 32'h5c220af2, 32'h5c220af2, 32'h5c220af2),
                     st(32'h5c220af2, 32'h5c220af2, 32'h5c220af2, 32'h5c220af2)};
    bus.req_valid = 2'b11;
    #1;
    check("reset out_valid", 128'(bus.out_valid), 128'd0);
    check("reset out_data", bus.out_data, 128'd0);
    check("reset out_id", 128'(bus.out_id), 128'd0);
    check("reset busy", 128'(busy), 128'd0);
    check("reset req_ready", 128'(bus.req_ready), 128'd0);

    // Both lanes from reset: lane 0 first, then lane 1.
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rr first grant", 128'(bus.req_ready), 128'd1);
    @(negedge clk);
    bus.req_valid[0] = 1'b0;
    check("rr busy after accept", 128'(busy), 128'd1);
    check("rr no grant while busy", 128'(bus.req_ready), 128'd0);
    wait_out_valid("rr lane0");
    check("rr lane0 data", bus.out_data,
          st(32'h9d58dc9f, 32'h9d58dc9f, 32'h9d58dc9f, 32'h9d58dc9f));
    check("rr lane0 id", 128'(bus.out_id), 128'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    #1;
    check("rr second grant", 128'(bus.req_ready), 128'd2);
    @(negedge clk);
    bus.req_valid[1] = 1'b0;
    wait_out_valid("rr lane1");
    check("rr lane1 data", bus.out_data,
          st(32'h9d58dc9f, 32'h9d58dc9f, 32'h9d58dc9f, 32'h9d58dc9f));
    check("rr lane1 id", 128'(bus.out_id), 128'd1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_one(vecs[i].name, 0, vecs[i].data, vecs[i].inv, vecs[i].exp);
    end

    // Output stall: result must hold while lane 1 waits.
    @(negedge clk);
    bus.req_data[127:0] = st(32'h01010101, 32'h01010101, 32'h01010101, 32'h455313db);
    bus.req_valid[0]    = 1'b1;
    #1;
    check("stall grant lane0", 128'(bus.req_ready), 128'd1);
    @(negedge clk);
    bus.req_valid[0]      = 1'b0;
    bus.req_data[255:128] = st(32'hc6c6c6c6, 32'hc6c6c6c6, 32'hc6c6c6c6, 32'hc6c6c6c6);
    bus.req_valid[1]      = 1'b1;
    wait_out_valid("stall");
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("stall out_data", bus.out_data,
            st(32'h01010101, 32'h01010101, 32'h01010101, 32'hbca14d8e));
      check("stall out_id", 128'(bus.out_id), 128'd0);
      check("stall out_valid", 128'(bus.out_valid), 128'd1);
      check("stall req_ready", 128'(bus.req_ready), 128'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    #1;
    check("stall release out_valid", 128'(bus.out_valid), 128'd0);
    check("stall release busy", 128'(busy), 128'd0);
    check("stall release grant lane1", 128'(bus.req_ready), 128'd2);
    @(negedge clk);
    bus.req_valid[1] = 1'b0;
    wait_out_valid("stall lane1");
    check("stall lane1 data", bus.out_data,
          st(32'hc6c6c6c6, 32'hc6c6c6c6, 32'hc6c6c6c6, 32'hc6c6c6c6));
    check("stall lane1 id", 128'(bus.out_id), 128'd1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;

    // Reset in the middle of a block, then a clean block.
    @(negedge clk);
    bus.req_data[127:0] = st(32'h5c220af2, 32'h455313db, 32'h4c31262d, 32'hd5d4d4d4);
    bus.req_valid[0]    = 1'b1;
    #1;
    check("midrst grant", 128'(bus.req_ready), 128'd1);
    @(negedge clk);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst out_valid", 128'(bus.out_valid), 128'd0);
    check("midrst out_data", bus.out_data, 128'd0);
    check("midrst out_id", 128'(bus.out_id), 128'd0);
    check("midrst busy", 128'(busy), 128'd0);
    check("midrst req_ready", 128'(bus.req_ready), 128'd0);
    @(negedge clk);
    rst              = 1'b0;
    bus.req_valid[0] = 1'b0;
    run_one("after reset", 0, st(32'h5c220af2, 32'h455313db, 32'h4c31262d, 32'hd5d4d4d4), 1'b0,
            st(32'h9d58dc9f, 32'hbca14d8e, 32'hf8bd7e4d, 32'hd6d7d5d5));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mixcol_sched.md
# mixcol_sched

Round-robin scheduler sharing one column-wide MixColumns engine between NREQ cipher lanes. It accepts a 128-bit state from one requester at a time and pushes it through a single 32-bit column unit, one column per clock. It returns the mixed state with the requester's ID over a valid/ready output handshake. It sits between the per-lane ShiftRows stage and AddRoundKey, replacing one full-width mixer per lane.

## Interface
- NREQ, 2: number of requesters, legal 2..4
- IDW, $clog2(NREQ): width of out_id
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  requester i presents a state
- req_ready  out  NREQ  requester i is granted this cycle
- req_data  in  128*NREQ  state of requester i at [128i +: 128]
- req_inv  in  NREQ  request inverse MixColumns; ignored unless MIXCOL_SCHED_INV_EN
- out_valid  out  1  mixed state available
- out_ready  in  1  consumer accepts out_data
- out_data  out  128  mixed state
- out_id  out  IDW  index of the requester that owns out_data
- busy  out  1  high in BUSY or DONE

## Operation
- Byte layout: column c = bits [32c +: 32], row r of column c = [32c+8r +: 8]; byte 0 in the LSBs.
- Forward mix per column: o0=2a0^3a1^a2^a3, o1=a0^2a1^3a2^a3, o2=a0^a1^2a2^3a3, o3=3a0^a1^a2^2a3. GF(2^8) with polynomial 0x11B.
- FSM states:
  - IDLE: grant computed; on a handshake, capture the state, id and inv into work regs, set col=0, go to BUSY.
  - BUSY: the column unit processes work[col] and writes it back in place. col increments; after col==3, go to DONE.
  - DONE: out_valid=1. On out_valid&&out_ready, go to IDLE.
- Grant: round-robin starting after last_id. Grant is combinational from req_valid in IDLE only. At most one req_ready bit is high. req_ready is 0 outside IDLE.
- A handshake is req_valid[i]&&req_ready[i]. req_ready does not depend on req_valid of the same requester, except through the grant choice.
- Simultaneous requests: the lowest index at or after (last_id+1) mod NREQ wins. last_id updates on acceptance.
- A requester may drop req_valid before being granted; there is no penalty.
- out_data and out_id hold stable while out_valid && !out_ready.
- DONE→IDLE takes one cycle. No new acceptance happens in the same cycle as output handshake.

## Timing
- Reset values: state=IDLE, col=0, last_id=NREQ-1 (so requester 0 is served first), out_valid=0, out_data=0, out_id=0, busy=0, req_ready=0 while rst is high.
- Latency: acceptance edge E0; columns 0..3 written at E1..E4; out_valid is high from E4 onward.
- Minimum issue interval is 6 cycles per block (accept, 4 column cycles, DONE, then IDLE).
- With out_ready held low, the block stays in DONE indefinitely and no requests are accepted.
- Reset mid-operation (BUSY or DONE) discards the work state immediately. No partial result is ever presented.
- out_valid and busy are registered outputs. req_ready is combinational from state, last_id and req_valid.

## Configuration
- MIXCOL_SCHED_INV_EN defined: req_inv is captured on acceptance. An inv=1 request uses the inverse matrix [0e 0b 0d 09] (rotated per row). Latency is unchanged.
- MIXCOL_SCHED_INV_EN undefined: req_inv is ignored, only the forward matrix is built, and the inverse multiplier logic is absent.

## Structure
- aes_pkg holds:
  - xtime function and gf_mul constants
  - the column-mix function (forward, and inverse under the macro)
  - the FSM state enum {IDLE, BUSY, DONE}
  - the byte/column index constants
- Sub-module mix_column_unit: combinational, 32-bit in, 32-bit out, plus an inv select. It is instantiated once. The scheduler owns all registers.

## Test plan
- Single request, column 0 = 0x455313db and the others 0x01010101 → out_data column 0 = 0xbca14d8e, others 0x01010101; out_id=0; out_valid high exactly 4 edges after acceptance.
- Both requesters valid from reset, each column 0x5c220af2 → requester 0 is served first, then requester 1. Both results have column 0 = 0x9d58dc9f, with out_id sequence 0,1.
- out_ready held low 10 cycles in DONE → out_data/out_id stable, req_ready all 0, no second acceptance; release → IDLE next cycle.
- rst pulsed at the cycle after E2 → all outputs return to reset values asynchronously, and the next request completes with the correct result.
- All columns 0xc6c6c6c6 → out_data unchanged. All columns 0x01010101 → out_data unchanged.
- MIXCOL_SCHED_INV_EN: inv=1, column 0 = 0xbca14d8e → out column 0 = 0x455313db. Without the macro, the same stimulus gives the forward result.
